id_ex_pipe: RTL and testbench

//  ID/EX pipeline register of the RV32 core. Registers decoded operands, register indices and

---
 rtl/id_ex_pipe.sv | 115 +++++++++++
 tb/tb_id_ex_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register: carries decoded operands into EX, inserts load-use bubbles,
// and applies branch flush and EX-busy hold.
module id_ex_pipe #(
    parameter int unsigned CTRL_W       = 16,
    parameter int unsigned LOAD_BUBBLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ID_valid,
    input  logic [31:0]       ID_pc,
    input  logic [4:0]        ID_rs1,
    input  logic [4:0]        ID_rs2,
    input  logic [4:0]        ID_rd,
    input  logic [2:0]        ID_ValidReg,
    input  logic [31:0]       ID_rs1_data,
    input  logic [31:0]       ID_rs2_data,
    input  logic [31:0]       ID_imm,
    input  logic [CTRL_W-1:0] ID_ctrl,
    input  logic              ID_is_load,
    input  logic              flush,
    input  logic              ex_busy,
    output logic              ID_stall,
    output logic              EX_valid,
    output logic              EX_is_load,
    output logic [31:0]       EX_pc,
    output logic [31:0]       EX_rs1_data,
    output logic [31:0]       EX_rs2_data,
    output logic [31:0]       EX_imm,
    output logic [4:0]        EX_rs1,
    output logic [4:0]        EX_rs2,
    output logic [4:0]        EX_rd,
    output logic [2:0]        EX_ValidReg,
    output logic [CTRL_W-1:0] EX_ctrl,
    output logic [CNT_W-1:0]  lu_bubble_cnt
);

    typedef enum logic [0:0] {StRun, StStall} state_e;

    localparam logic [1:0] BubInit = 2'(LOAD_BUBBLES - 1);

    state_e     state_q;
    logic [1:0] cnt_q;
    logic       hz;
    logic       bubble;

    always_comb begin
        hz = ID_valid & EX_valid & EX_is_load & EX_ValidReg[0] &
             ((ID_ValidReg[1] & (ID_rs1 == EX_rd)) | (ID_ValidReg[2] & (ID_rs2 == EX_rd)));
        bubble   = ((state_q == StRun) & hz) | ((state_q == StStall) & (cnt_q != 2'd0));
        ID_stall = ~flush & (ex_busy | bubble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            cnt_q         <= 2'd0;
            EX_valid      <= 1'b0;
            EX_is_load    <= 1'b0;
            EX_pc         <= '0;
            EX_rs1_data   <= '0;
            EX_rs2_data   <= '0;
            EX_imm        <= '0;
            EX_rs1        <= '0;
            EX_rs2        <= '0;
            EX_rd         <= '0;
            EX_ValidReg   <= '0;
            EX_ctrl       <= '0;
            lu_bubble_cnt <= '0;
        end else if (flush || (!ex_busy && bubble)) begin
            // Flush and load-use bubbles both empty EX; only the latter advance the FSM/counter.
            EX_valid    <= 1'b0;
            EX_is_load  <= 1'b0;
            EX_pc       <= '0;
            EX_rs1_data <= '0;
            EX_rs2_data <= '0;
            EX_imm      <= '0;
            EX_rs1      <= '0;
            EX_rs2      <= '0;
            EX_rd       <= '0;
            EX_ValidReg <= '0;
            EX_ctrl     <= '0;
            if (flush) begin
                state_q <= StRun;
                cnt_q   <= 2'd0;
            end else begin
                if (state_q == StRun) begin
                    state_q <= StStall;
                    cnt_q   <= BubInit;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
                if (lu_bubble_cnt != '1) begin
                    lu_bubble_cnt <= lu_bubble_cnt + 1'b1;
                end
            end
        end else if (!ex_busy) begin
            state_q     <= StRun;
            cnt_q       <= 2'd0;
            EX_valid    <= ID_valid;
            EX_is_load  <= ID_is_load;
            EX_pc       <= ID_pc;
            EX_rs1_data <= ID_rs1_data;
            EX_rs2_data <= ID_rs2_data;
            EX_imm      <= ID_imm;
            EX_rs1      <= ID_rs1;
            EX_rs2      <= ID_rs2;
            EX_rd       <= ID_rd;
            EX_ctrl     <= ID_ctrl;
            // rd write flag dropped for x0 so x0 can never raise a hazard.
            EX_ValidReg <= ID_valid ? (ID_ValidReg & {2'b11, ID_rd != 5'd0}) : 3'b000;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Bench for id_ex_pipe: two instances (1 bubble / 2-bit counter, 2 bubbles / 32-bit counter)
// driven in parallel; a select picks which one is checked against the scoreboard.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_is_load, flush, ex_busy;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_vr;
    logic [15:0] id_ctrl;

    logic        stall_a, valid_a, ld_a, stall_b, valid_b, ld_b;
    logic [31:0] pc_a, d1_a, d2_a, imm_a, pc_b, d1_b, d2_b, imm_b;
    logic [4:0]  rs1_a, rs2_a, rd_a, rs1_b, rs2_b, rd_b;
    logic [2:0]  vr_a, vr_b;
    logic [15:0] ctrl_a, ctrl_b;
    logic [1:0]  cnt_a;
    logic [31:0] cnt_b;

    logic        sel;
    logic        stall, ex_valid, ex_ld;
    logic [31:0] ex_pc, ex_d1, ex_d2, ex_imm, ex_cnt;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_vr;
    logic [15:0] ex_ctrl;

    always #5 clk = ~clk;

    id_ex_pipe #(.CTRL_W(16), .LOAD_BUBBLES(1), .CNT_W(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ID_valid(id_valid), .ID_pc(id_pc), .ID_rs1(id_rs1),
        .ID_rs2(id_rs2), .ID_rd(id_rd), .ID_ValidReg(id_vr), .ID_rs1_data(id_rs1_data),
        .ID_rs2_data(id_rs2_data), .ID_imm(id_imm), .ID_ctrl(id_ctrl), .ID_is_load(id_is_load),
        .flush(flush), .ex_busy(ex_busy), .ID_stall(stall_a), .EX_valid(valid_a),
        .EX_is_load(ld_a), .EX_pc(pc_a), .EX_rs1_data(d1_a), .EX_rs2_data(d2_a), .EX_imm(imm_a),
        .EX_rs1(rs1_a), .EX_rs2(rs2_a), .EX_rd(rd_a), .EX_ValidReg(vr_a), .EX_ctrl(ctrl_a),
        .lu_bubble_cnt(cnt_a)
    );

    id_ex_pipe #(.CTRL_W(16), .LOAD_BUBBLES(2), .CNT_W(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ID_valid(id_valid), .ID_pc(id_pc), .ID_rs1(id_rs1),
        .ID_rs2(id_rs2), .ID_rd(id_rd), .ID_ValidReg(id_vr), .ID_rs1_data(id_rs1_data),
        .ID_rs2_data(id_rs2_data), .ID_imm(id_imm), .ID_ctrl(id_ctrl), .ID_is_load(id_is_load),
        .flush(flush), .ex_busy(ex_busy), .ID_stall(stall_b), .EX_valid(valid_b),
        .EX_is_load(ld_b), .EX_pc(pc_b), .EX_rs1_data(d1_b), .EX_rs2_data(d2_b), .EX_imm(imm_b),
        .EX_rs1(rs1_b), .EX_rs2(rs2_b), .EX_rd(rd_b), .EX_ValidReg(vr_b), .EX_ctrl(ctrl_b),
        .lu_bubble_cnt(cnt_b)
    );

    always_comb begin
        stall    = sel ? stall_b : stall_a;
        ex_valid = sel ? valid_b : valid_a;
        ex_ld    = sel ? ld_b    : ld_a;
        ex_pc    = sel ? pc_b    : pc_a;
        ex_d1    = sel ? d1_b    : d1_a;
        ex_d2    = sel ? d2_b    : d2_a;
        ex_imm   = sel ? imm_b   : imm_a;
        ex_rs1   = sel ? rs1_b   : rs1_a;
        ex_rs2   = sel ? rs2_b   : rs2_a;
        ex_rd    = sel ? rd_b    : rd_a;
        ex_vr    = sel ? vr_b    : vr_a;
        ex_ctrl  = sel ? ctrl_b  : ctrl_a;
        ex_cnt   = sel ? cnt_b   : {30'd0, cnt_a};
    end

    typedef struct {
        logic        valid;
        logic        is_load;
        logic [31:0] pc, d1, d2, imm, cnt;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  vr;
        logic [15:0] ctrl;
        int          mode;
    } exp_t;

    localparam int Cap = 0, Bub = 1, Hold = 2;

    exp_t sb[$];
    exp_t last;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [2:0] vr,
                          input logic ld);
        id_valid    = v;
        id_pc       = pc;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_vr       = vr;
        id_is_load  = ld;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h0000_5A5A;
        id_imm      = pc + 32'd4;
        id_ctrl     = pc[15:0] ^ 16'hBEEF;
    endtask

    // One clock: check the combinational stall, queue the expected EX contents, clock, compare.
    task automatic cyc(input string tag, input logic exp_stall, input int mode,
                       input int exp_cnt);
        exp_t e;
        #2;
        check_eq({tag, ".stall"}, 64'(stall), 64'(exp_stall));
        e = '{default: 0};
        if (mode == Cap) begin
            e.valid   = id_valid;
            e.is_load = id_is_load;
            e.pc      = id_pc;
            e.d1      = id_rs1_data;
            e.d2      = id_rs2_data;
            e.imm     = id_imm;
            e.rs1     = id_rs1;
            e.rs2     = id_rs2;
            e.rd      = id_rd;
            e.ctrl    = id_ctrl;
            e.vr      = id_valid ? (id_vr & {2'b11, id_rd != 5'd0}) : 3'b000;
        end else if (mode == Hold) begin
            e = last;
        end
        e.cnt  = 32'(exp_cnt);
        e.mode = mode;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last = e;
        check_eq({tag, ".valid"}, 64'(ex_valid), 64'(e.valid));
        check_eq({tag, ".vr"},    64'(ex_vr),    64'(e.vr));
        check_eq({tag, ".ld"},    64'(ex_ld),    64'(e.is_load));
        check_eq({tag, ".rd"},    64'(ex_rd),    64'(e.rd));
        check_eq({tag, ".ctrl"},  64'(ex_ctrl),  64'(e.ctrl));
        check_eq({tag, ".cnt"},   64'(ex_cnt),   64'(e.cnt));
        if (e.mode != Bub) begin
            check_eq({tag, ".pc"},  64'(ex_pc),  64'(e.pc));
            check_eq({tag, ".rs1"}, 64'(ex_rs1), 64'(e.rs1));
            check_eq({tag, ".rs2"}, 64'(ex_rs2), 64'(e.rs2));
            check_eq({tag, ".d1"},  64'(ex_d1),  64'(e.d1));
            check_eq({tag, ".d2"},  64'(ex_d2),  64'(e.d2));
            check_eq({tag, ".imm"}, 64'(ex_imm), 64'(e.imm));
        end
    endtask

    // Asserts reset away from a clock edge and checks everything clears without one.
    task automatic do_reset(input string tag, input logic sel_v);
        sel = sel_v;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".valid"}, 64'(ex_valid), 64'd0);
        check_eq({tag, ".vr"},    64'(ex_vr),    64'd0);
        check_eq({tag, ".ld"},    64'(ex_ld),    64'd0);
        check_eq({tag, ".pc"},    64'(ex_pc),    64'd0);
        check_eq({tag, ".rd"},    64'(ex_rd),    64'd0);
        check_eq({tag, ".rs1"},   64'(ex_rs1),   64'd0);
        check_eq({tag, ".d1"},    64'(ex_d1),    64'd0);
        check_eq({tag, ".ctrl"},  64'(ex_ctrl),  64'd0);
        check_eq({tag, ".cnt"},   64'(ex_cnt),   64'd0);
        check_eq({tag, ".stall"}, 64'(stall),    64'd0);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
        flush   = 1'b0;
        ex_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last = '{default: 0};
    endtask

    initial begin
        rst_n   = 1'b1;
        sel     = 1'b0;
        flush   = 1'b0;
        ex_busy = 1'b0;
        set_id(1'b1, 32'h50, 5'd1, 5'd2, 5'd3, 3'b111, 1'b0);
        @(posedge clk);
        #1;
        do_reset("rst_a", 1'b0);

        // One bubble per load-use hazard, 2-bit counter.
        set_id(1'b1, 32'h100, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t2.lw", 1'b0, Cap, 0);
        set_id(1'b1, 32'h104, 5'd5, 5'd7, 5'd6, 3'b111, 1'b0);
        cyc("t2.bub", 1'b1, Bub, 1);
        cyc("t2.add", 1'b0, Cap, 1);
        set_id(1'b0, 32'h108, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0);
        cyc("t2.idle", 1'b0, Cap, 1);

        // Store reading only rs2 hazards; addi with a stale rs2 field does not.
        set_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t4.lw", 1'b0, Cap, 1);
        set_id(1'b1, 32'h204, 5'd8, 5'd5, 5'd0, 3'b110, 1'b0);
        cyc("t4.sw_bub", 1'b1, Bub, 2);
        cyc("t4.sw", 1'b0, Cap, 2);
        set_id(1'b1, 32'h210, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t4.lw2", 1'b0, Cap, 2);
        set_id(1'b1, 32'h214, 5'd8, 5'd5, 5'd6, 3'b011, 1'b0);
        cyc("t4.addi", 1'b0, Cap, 2);

        // EX busy holds for three cycles, then the waiting ID instruction is captured.
        set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd3, 3'b111, 1'b0);
        cyc("t6.a", 1'b0, Cap, 2);
        set_id(1'b1, 32'h304, 5'd3, 5'd2, 5'd4, 3'b111, 1'b0);
        ex_busy = 1'b1;
        for (int i = 0; i < 3; i++) cyc("t6.busy", 1'b1, Hold, 2);
        ex_busy = 1'b0;
        cyc("t6.b", 1'b0, Cap, 2);

        // Counter saturates at all-ones.
        set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd9, 3'b001, 1'b1);
        cyc("sat.lw", 1'b0, Cap, 2);
        set_id(1'b1, 32'h404, 5'd1, 5'd9, 5'd10, 3'b101, 1'b0);
        cyc("sat.bub1", 1'b1, Bub, 3);
        cyc("sat.add1", 1'b0, Cap, 3);
        set_id(1'b1, 32'h408, 5'd1, 5'd0, 5'd9, 3'b001, 1'b1);
        cyc("sat.lw2", 1'b0, Cap, 3);
        set_id(1'b1, 32'h40C, 5'd9, 5'd1, 5'd10, 3'b111, 1'b0);
        cyc("sat.bub2", 1'b1, Bub, 3);
        cyc("sat.add2", 1'b0, Cap, 3);

        do_reset("rst_b", 1'b1);

        // Two bubbles per hazard.
        set_id(1'b1, 32'h500, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t3.lw", 1'b0, Cap, 0);
        set_id(1'b1, 32'h504, 5'd5, 5'd7, 5'd6, 3'b111, 1'b0);
        cyc("t3.bub1", 1'b1, Bub, 1);
        cyc("t3.bub2", 1'b1, Bub, 2);
        cyc("t3.add", 1'b0, Cap, 2);
        set_id(1'b1, 32'h510, 5'd1, 5'd0, 5'd0, 3'b001, 1'b1);
        cyc("t3.lw_x0", 1'b0, Cap, 2);
        set_id(1'b1, 32'h514, 5'd0, 5'd7, 5'd6, 3'b111, 1'b0);
        cyc("t3.add_x0", 1'b0, Cap, 2);

        // Flush in the first stall cycle abandons the remaining bubble.
        set_id(1'b1, 32'h600, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t5.lw", 1'b0, Cap, 2);
        set_id(1'b1, 32'h604, 5'd5, 5'd7, 5'd6, 3'b111, 1'b0);
        cyc("t5.bub", 1'b1, Bub, 3);
        flush = 1'b1;
        cyc("t5.flush", 1'b0, Bub, 3);
        flush = 1'b0;
        cyc("t5.after", 1'b0, Cap, 3);

        // Reset in the middle of a stall.
        set_id(1'b1, 32'h700, 5'd1, 5'd0, 5'd5, 3'b001, 1'b1);
        cyc("t1.lw", 1'b0, Cap, 3);
        set_id(1'b1, 32'h704, 5'd5, 5'd7, 5'd6, 3'b111, 1'b0);
        cyc("t1.bub", 1'b1, Bub, 4);
        do_reset("t1.rst", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
